vid_capture_ctrl: RTL and testbench

Frame capture controller for the HDMI/VGA pixel stream (hdmi_de/hdmi_hs/hdmi_vs plus 24-bit RGB). On a host request it arms, aligns to the next vertical sync, and forwards one complete frame of pixels with x/y coordinates to the downstream processing pipeline. It then reports done and any geometry errors. It sits between the video input and the per-pixel neural/skin-detection datapath and is the only block that starts or stops frame processing.

---
 rtl/vid_capture_ctrl.sv | 171 +++++++++++++++++
 tb/tb_vid_capture_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_capture_ctrl.sv
// rtl/vid_capture_ctrl.sv - one-shot frame capture controller for the HDMI/VGA pixel stream
// Optional geometry checking (err_line / err_frame) is built when GEOMETRY_CHECK_EN is defined.
module vid_capture_ctrl #(
   parameter int H_RES = 64,
   parameter int V_RES = 64,
   parameter int CW    = 11
) (
   input  logic          hdmi_clk,
   input  logic          rst_n,
   input  logic          hdmi_de,
   input  logic          hdmi_hs,
   input  logic          hdmi_vs,
   input  logic [7:0]    hdmi_r,
   input  logic [7:0]    hdmi_g,
   input  logic [7:0]    hdmi_b,
   input  logic          cap_req,
   input  logic          cap_abort,
   output logic          cap_busy,
   output logic          cap_done,
   output logic          px_valid,
   output logic [CW-1:0] px_x,
   output logic [CW-1:0] px_y,
   output logic [23:0]   px_rgb,
   output logic [7:0]    frame_cnt,
   output logic          err_line,
   output logic          err_frame
);

   localparam logic [CW-1:0] H_END = CW'(H_RES);
   localparam logic [CW-1:0] V_END = CW'(V_RES);
   localparam logic [CW-1:0] C_MAX = '1;

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

   state_t        state;
   logic          de_d1;
   logic          hs_d1;
   logic          vs_d1;
   logic [23:0]   rgb_d1;
   logic [CW-1:0] x;
   logic [CW-1:0] y;
   logic [CW-1:0] x_inc;
   logic [CW-1:0] y_inc;
   logic          vs_fall;
   logic          de_fall;
   logic          accept;
   logic          enter_done;
   logic          unused_hs;

   assign vs_fall   = vs_d1 & ~hdmi_vs;
   assign de_fall   = de_d1 & ~hdmi_de;
   // Counters stick at all-ones instead of wrapping back into the valid window.
   assign x_inc     = (x == C_MAX) ? x : x + 1'b1;
   assign y_inc     = (y == C_MAX) ? y : y + 1'b1;
   // Abort beats a simultaneous request, so the request is simply dropped.
   assign accept    = (state == IDLE) && cap_req && !cap_abort;
   // Frame ends after the last line has been counted, or early on a new vsync.
   assign enter_done = (state == CAPTURE) && !cap_abort && ((y >= V_END) || vs_fall);
   // Horizontal sync carries no information this block needs; it is only registered.
   assign unused_hs = hs_d1;

   // Input register stage for the raw video signals
   always_ff @(posedge hdmi_clk) begin
      if (!rst_n) begin
         de_d1  <= 1'b0;
         hs_d1  <= 1'b0;
         vs_d1  <= 1'b0;
         rgb_d1 <= '0;
      end else begin
         de_d1  <= hdmi_de;
         hs_d1  <= hdmi_hs;
         vs_d1  <= hdmi_vs;
         rgb_d1 <= {hdmi_r, hdmi_g, hdmi_b};
      end
   end

   // Capture sequencer, pixel coordinate counters and registered outputs
   always_ff @(posedge hdmi_clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         x         <= '0;
         y         <= '0;
         cap_busy  <= 1'b0;
         cap_done  <= 1'b0;
         px_valid  <= 1'b0;
         px_x      <= '0;
         px_y      <= '0;
         px_rgb    <= '0;
         frame_cnt <= '0;
      end else begin
         cap_done <= 1'b0;
         px_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state    <= ARMED;
                  cap_busy <= 1'b1;
               end
            end
            ARMED: begin
               if (cap_abort) begin
                  state    <= IDLE;
                  cap_busy <= 1'b0;
               end else if (vs_fall) begin
                  state <= CAPTURE;
                  x     <= '0;
                  y     <= '0;
               end
            end
            CAPTURE: begin
               if (cap_abort) begin
                  state    <= IDLE;
                  cap_busy <= 1'b0;
               end else if (enter_done) begin
                  state     <= DONE;
                  cap_done  <= 1'b1;
                  frame_cnt <= frame_cnt + 8'd1;
               end else if (de_d1) begin
                  if ((x < H_END) && (y < V_END)) begin
                     px_valid <= 1'b1;
                     px_x     <= x;
                     px_y     <= y;
                     px_rgb   <= rgb_d1;
                  end
                  if (de_fall) begin
                     x <= '0;
                     y <= y_inc;
                  end else begin
                     x <= x_inc;
                  end
               end
            end
            DONE: begin
               state    <= IDLE;
               cap_busy <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               cap_busy <= 1'b0;
            end
         endcase
      end
   end

`ifdef GEOMETRY_CHECK_EN
   logic cap_pix;

   assign cap_pix = (state == CAPTURE) && !cap_abort && !enter_done && de_d1;

   // Sticky geometry flags; at de_fall the line's last pixel is still in de_d1,
   // so the run length is x_inc rather than x.
   always_ff @(posedge hdmi_clk) begin
      if (!rst_n) begin
         err_line  <= 1'b0;
         err_frame <= 1'b0;
      end else if (accept) begin
         err_line  <= 1'b0;
         err_frame <= 1'b0;
      end else begin
         if (cap_pix && de_fall && (x_inc != H_END))
            err_line <= 1'b1;
         if (enter_done && (y != V_END))
            err_frame <= 1'b1;
      end
   end
`else
   assign err_line  = 1'b0;
   assign err_frame = 1'b0;
`endif

endmodule

// File: tb/tb_vid_capture_ctrl.sv
// tb/tb_vid_capture_ctrl.sv - directed vector and frame-sequence bench for vid_capture_ctrl
module tb_vid_capture_ctrl;

`ifdef GEOMETRY_CHECK_EN
   localparam logic GC = 1'b1;
`else
   localparam logic GC = 1'b0;
`endif

   localparam logic [23:0] RA = 24'h123456;
   localparam logic [23:0] RB = 24'hABCDEF;

   logic        hdmi_clk;
   logic        rst_n;
   logic        hdmi_de;
   logic        hdmi_hs;
   logic        hdmi_vs;
   logic [7:0]  hdmi_r;
   logic [7:0]  hdmi_g;
   logic [7:0]  hdmi_b;
   logic        cap_req;
   logic        cap_abort;
   logic        cap_busy;
   logic        cap_done;
   logic        px_valid;
   logic [10:0] px_x;
   logic [10:0] px_y;
   logic [23:0] px_rgb;
   logic [7:0]  frame_cnt;
   logic        err_line;
   logic        err_frame;

   vid_capture_ctrl #(.H_RES(64), .V_RES(64), .CW(11)) dut (
      .hdmi_clk  (hdmi_clk),
      .rst_n     (rst_n),
      .hdmi_de   (hdmi_de),
      .hdmi_hs   (hdmi_hs),
      .hdmi_vs   (hdmi_vs),
      .hdmi_r    (hdmi_r),
      .hdmi_g    (hdmi_g),
      .hdmi_b    (hdmi_b),
      .cap_req   (cap_req),
      .cap_abort (cap_abort),
      .cap_busy  (cap_busy),
      .cap_done  (cap_done),
      .px_valid  (px_valid),
      .px_x      (px_x),
      .px_y      (px_y),
      .px_rgb    (px_rgb),
      .frame_cnt (frame_cnt),
      .err_line  (err_line),
      .err_frame (err_frame)
   );

   initial hdmi_clk = 1'b0;
   always #5 hdmi_clk = ~hdmi_clk;

   typedef struct {
      logic        rst_n;
      logic        req;
      logic        abort;
      logic        vs;
      logic        de;
      logic [23:0] rgb;
      logic        busy;
      logic        done;
      logic        pv;
      logic [10:0] x;
      logic [10:0] y;
      logic [23:0] rgb_o;
      logic [7:0]  fc;
      logic        el;
      logic        ef;
   } vec_t;

   vec_t        tbl [15];
   int          n_vec = 0;
   int          n_miss = 0;
   int          exp_fc;
   logic [23:0] pix;

   int          pv_cnt = 0;
   int          done_cnt = 0;
   int          mon_bad = 0;
   int          mx = 0;
   int          my = 0;
   int          last_x = 0;
   int          last_y = 0;
   logic        mon_chk = 1'b0;
   logic [23:0] prev_rgb = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic vline(input bit vs_low, input int de_len);
      for (int c = 0; c < 83; c++) begin
         @(negedge hdmi_clk);
         hdmi_vs = !(vs_low && c < 4);
         hdmi_hs = !(c >= 70 && c < 76);
         hdmi_de = (c < de_len);
         pix = pix + 24'd1;
         {hdmi_r, hdmi_g, hdmi_b} = pix;
      end
   endtask

   task automatic send_frame(input int n_act, input int short_line);
      vline(1'b1, 0);
      vline(1'b0, 0);
      for (int l = 0; l < n_act; l++) vline(1'b0, (l == short_line) ? 60 : 64);
      vline(1'b0, 0);
   endtask

   task automatic pulse_req();
      @(negedge hdmi_clk);
      cap_req = 1'b1;
      @(negedge hdmi_clk);
      cap_req = 1'b0;
   endtask

   // Pixel stream model: raster order from (0,0) and rgb equal to the input two edges back
   always @(posedge hdmi_clk) begin
      #1;
      if (cap_done) done_cnt++;
      if (px_valid) begin
         pv_cnt++;
         last_x = int'(px_x);
         last_y = int'(px_y);
         if (mon_chk && (int'(px_x) != mx || int'(px_y) != my || px_rgb !== prev_rgb)) mon_bad++;
         mx++;
         if (mx == 64) begin
            mx = 0;
            my++;
         end
      end
      if (!cap_busy) begin
         mx = 0;
         my = 0;
      end
      prev_rgb = {hdmi_r, hdmi_g, hdmi_b};
   end

   initial begin
      int  d0;
      int  p0;
      bit  found;

      rst_n = 1'b0;
      hdmi_de = 1'b0;
      hdmi_hs = 1'b1;
      hdmi_vs = 1'b1;
      {hdmi_r, hdmi_g, hdmi_b} = 24'h0;
      cap_req = 1'b0;
      cap_abort = 1'b0;
      pix = 24'h0;

      //            rst req ab  vs  de  rgb    busy done pv  x  y  rgb_o fc el  ef
      tbl[0]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,24'h0, 1'b0,1'b0,1'b0,11'd0,11'd0,24'h0,8'd0,1'b0,1'b0};
      tbl[1]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,24'h0, 1'b0,1'b0,1'b0,11'd0,11'd0,24'h0,8'd0,1'b0,1'b0};
      tbl[2]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,24'h0, 1'b0,1'b0,1'b0,11'd0,11'd0,24'h0,8'd0,1'b0,1'b0};
      tbl[3]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,24'h0, 1'b1,1'b0,1'b0,11'd0,11'd0,24'h0,8'd0,1'b0,1'b0};
      tbl[4]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,24'h0, 1'b1,1'b0,1'b0,11'd0,11'd0,24'h0,8'd0,1'b0,1'b0};
      tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,24'h0, 1'b1,1'b0,1'b0,11'd0,11'd0,24'h0,8'd0,1'b0,1'b0};
      tbl[6]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,RA,    1'b1,1'b0,1'b0,11'd0,11'd0,24'h0,8'd0,1'b0,1'b0};
      tbl[7]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,RB,    1'b1,1'b0,1'b1,11'd0,11'd0,RA,   8'd0,1'b0,1'b0};
      tbl[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,24'h0, 1'b1,1'b0,1'b1,11'd1,11'd0,RB,   8'd0,GC,  1'b0};
      tbl[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,24'h0, 1'b1,1'b0,1'b0,11'd1,11'd0,RB,   8'd0,GC,  1'b0};
      tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,24'h0, 1'b1,1'b1,1'b0,11'd1,11'd0,RB,   8'd1,GC,  GC};
      tbl[11] = '{1'b1,1'b0,1'b0,1'b1,1'b0,24'h0, 1'b0,1'b0,1'b0,11'd1,11'd0,RB,   8'd1,GC,  GC};
      tbl[12] = '{1'b1,1'b1,1'b0,1'b1,1'b0,24'h0, 1'b1,1'b0,1'b0,11'd1,11'd0,RB,   8'd1,1'b0,1'b0};
      tbl[13] = '{1'b1,1'b0,1'b1,1'b1,1'b0,24'h0, 1'b0,1'b0,1'b0,11'd1,11'd0,RB,   8'd1,1'b0,1'b0};
      tbl[14] = '{1'b1,1'b0,1'b0,1'b1,1'b0,24'h0, 1'b0,1'b0,1'b0,11'd1,11'd0,RB,   8'd1,1'b0,1'b0};

      for (int i = 0; i < 15; i++) begin
         @(negedge hdmi_clk);
         rst_n = tbl[i].rst_n;
         cap_req = tbl[i].req;
         cap_abort = tbl[i].abort;
         hdmi_vs = tbl[i].vs;
         hdmi_de = tbl[i].de;
         {hdmi_r, hdmi_g, hdmi_b} = tbl[i].rgb;
         @(posedge hdmi_clk);
         #1;
         chk($sformatf("v%0d_busy", i), 32'(cap_busy), 32'(tbl[i].busy));
         chk($sformatf("v%0d_done", i), 32'(cap_done), 32'(tbl[i].done));
         chk($sformatf("v%0d_pv", i), 32'(px_valid), 32'(tbl[i].pv));
         chk($sformatf("v%0d_x", i), 32'(px_x), 32'(tbl[i].x));
         chk($sformatf("v%0d_y", i), 32'(px_y), 32'(tbl[i].y));
         chk($sformatf("v%0d_rgb", i), 32'(px_rgb), 32'(tbl[i].rgb_o));
         chk($sformatf("v%0d_fc", i), 32'(frame_cnt), 32'(tbl[i].fc));
         chk($sformatf("v%0d_err_line", i), 32'(err_line), 32'(tbl[i].el));
         chk($sformatf("v%0d_err_frame", i), 32'(err_frame), 32'(tbl[i].ef));
      end
      @(negedge hdmi_clk);
      cap_req = 1'b0;
      cap_abort = 1'b0;
      hdmi_vs = 1'b1;
      hdmi_de = 1'b0;
      exp_fc = 1;

      // Request mid-frame; a second request during the capture must be ignored
      mon_chk = 1'b1;
      d0 = done_cnt;
      p0 = pv_cnt;
      fork
         begin
            send_frame(64, -1);
            send_frame(64, -1);
         end
         begin
            repeat (20 * 83) @(negedge hdmi_clk);
            pulse_req();
            repeat (67 * 83) @(negedge hdmi_clk);
            pulse_req();
         end
      join
      exp_fc++;
      chk("main_px_count", pv_cnt - p0, 4096);
      chk("main_done_count", done_cnt - d0, 1);
      chk("main_frame_cnt", 32'(frame_cnt), exp_fc);
      chk("main_pixel_stream", mon_bad, 0);
      chk("main_last_x", last_x, 63);
      chk("main_last_y", last_y, 63);
      chk("main_busy_after", 32'(cap_busy), 0);
      chk("main_err_line", 32'(err_line), 0);
      chk("main_err_frame", 32'(err_frame), 0);

      // Abort at line 10, then capture the next full frame
      pulse_req();
      d0 = done_cnt;
      p0 = pv_cnt;
      fork
         begin
            send_frame(64, -1);
            send_frame(64, -1);
         end
         begin
            found = 1'b0;
            for (int i = 0; i < 20000 && !found; i++) begin
               @(posedge hdmi_clk);
               #2;
               if (px_valid && px_y == 11'd10) found = 1'b1;
            end
            chk("abort_reach_y10", 32'(found), 1);
            @(negedge hdmi_clk);
            cap_abort = 1'b1;
            @(posedge hdmi_clk);
            #2;
            chk("abort_busy", 32'(cap_busy), 0);
            chk("abort_pv", 32'(px_valid), 0);
            @(negedge hdmi_clk);
            cap_abort = 1'b0;
            repeat (200) @(negedge hdmi_clk);
            chk("abort_no_done", done_cnt - d0, 0);
            chk("abort_frame_cnt", 32'(frame_cnt), exp_fc);
            p0 = pv_cnt;
            pulse_req();
         end
      join
      exp_fc++;
      chk("after_abort_px_count", pv_cnt - p0, 4096);
      chk("after_abort_done", done_cnt - d0, 1);
      chk("after_abort_frame_cnt", 32'(frame_cnt), exp_fc);
      chk("after_abort_stream", mon_bad, 0);
      chk("after_abort_last_y", last_y, 63);

      // Geometry: short line 5, then early vsync after 40 lines
      mon_chk = 1'b0;
      pulse_req();
      d0 = done_cnt;
      send_frame(64, 5);
      exp_fc++;
      chk("short_done", done_cnt - d0, 1);
      chk("short_frame_cnt", 32'(frame_cnt), exp_fc);
      chk("short_err_line", 32'(err_line), 32'(GC));
      chk("short_err_frame", 32'(err_frame), 0);
      pulse_req();
      d0 = done_cnt;
      vline(1'b1, 0);
      vline(1'b0, 0);
      for (int l = 0; l < 40; l++) vline(1'b0, 64);
      vline(1'b1, 0);
      vline(1'b0, 0);
      exp_fc++;
      chk("early_vs_done", done_cnt - d0, 1);
      chk("early_vs_frame_cnt", 32'(frame_cnt), exp_fc);
      chk("early_vs_err_frame", 32'(err_frame), 32'(GC));
      chk("early_vs_err_line", 32'(err_line), 0);
      chk("early_vs_busy", 32'(cap_busy), 0);

      // Reset pulse in the middle of an active line during capture
      pulse_req();
      fork
         begin
            vline(1'b1, 0);
            vline(1'b0, 0);
            for (int l = 0; l < 3; l++) vline(1'b0, 64);
         end
         begin
            repeat (3 * 83 + 20) @(negedge hdmi_clk);
            rst_n = 1'b0;
            @(posedge hdmi_clk);
            #2;
            chk("rst_busy", 32'(cap_busy), 0);
            chk("rst_done", 32'(cap_done), 0);
            chk("rst_pv", 32'(px_valid), 0);
            chk("rst_px_x", 32'(px_x), 0);
            chk("rst_px_y", 32'(px_y), 0);
            chk("rst_px_rgb", 32'(px_rgb), 0);
            chk("rst_frame_cnt", 32'(frame_cnt), 0);
            chk("rst_err_line", 32'(err_line), 0);
            chk("rst_err_frame", 32'(err_frame), 0);
            @(negedge hdmi_clk);
            rst_n = 1'b1;
            p0 = pv_cnt;
         end
      join
      chk("rst_no_more_px", pv_cnt - p0, 0);
      chk("rst_stays_idle", 32'(cap_busy), 0);

      // 256 quick captures (vsync-terminated) to wrap frame_cnt
      d0 = done_cnt;
      for (int k = 0; k < 256; k++) begin
         @(negedge hdmi_clk);
         cap_req = 1'b1;
         @(negedge hdmi_clk);
         cap_req = 1'b0;
         hdmi_vs = 1'b0;
         @(negedge hdmi_clk);
         hdmi_vs = 1'b1;
         @(negedge hdmi_clk);
         hdmi_vs = 1'b0;
         @(negedge hdmi_clk);
         hdmi_vs = 1'b1;
         @(negedge hdmi_clk);
         if (k == 254) chk("wrap_fc_255", 32'(frame_cnt), 255);
      end
      chk("wrap_fc_0", 32'(frame_cnt), 0);
      chk("wrap_done_count", done_cnt - d0, 256);
      chk("wrap_busy", 32'(cap_busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
